// File: rtl/clock_time_set_pkg.sv
// rtl/clock_time_set_pkg.sv - shared types and constants for the clock time-setting front end
// Purpose: state encoding, BCD wrap limits and a BCD range helper used by clock_time_set.
// Ports: none (package).
package clock_time_set_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  localparam logic [3:0] HR_MAX_MS  = 4'd2;
  localparam logic [3:0] HR_MAX_LS  = 4'd3;
  localparam logic [3:0] MIN_MAX_MS = 4'd5;
  localparam logic [3:0] MIN_MAX_LS = 4'd9;

  // True when ms:ls is a legal two-digit BCD value no larger than max_ms:max_ls.
  function automatic logic bcd_in_range(input logic [3:0] ms, input logic [3:0] ls,
                                        input logic [3:0] max_ms, input logic [3:0] max_ls);
    return (ms <= 4'd9) && (ls <= 4'd9) &&
           ((ms < max_ms) || ((ms == max_ms) && (ls <= max_ls)));
  endfunction

endpackage

// File: rtl/clock_time_set_bcd_inc_wrap.sv
// rtl/clock_time_set_bcd_inc_wrap.sv - two-digit BCD increment with wrap to 00 at a fixed maximum
// Purpose: combinational +1 on a two-digit BCD value; MAX_MS:MAX_LS wraps to 00.
// Ports:
//   ms_i, ls_i : current tens / units digit (assumed legal BCD)
//   ms_o, ls_o : incremented tens / units digit
module bcd_inc_wrap #(
  parameter logic [3:0] MAX_MS = 4'd5,
  parameter logic [3:0] MAX_LS = 4'd9
) (
  input  logic [3:0] ms_i,
  input  logic [3:0] ls_i,
  output logic [3:0] ms_o,
  output logic [3:0] ls_o
);

  always_comb begin
    ms_o = ms_i;
    ls_o = ls_i;
    if ((ms_i == MAX_MS) && (ls_i == MAX_LS)) begin
      ms_o = 4'd0;
      ls_o = 4'd0;
    end else if (ls_i >= 4'd9) begin
      ms_o = ms_i + 4'd1;
      ls_o = 4'd0;
    end else begin
      ls_o = ls_i + 4'd1;
    end
  end

endmodule

// File: rtl/clock_time_set.sv
// rtl/clock_time_set.sv - button-driven BCD hh:mm editor that commits via a one-cycle load strobe
// Purpose: btn_set enters edit (capturing the current time), advances hours -> minutes,
//          then commits; btn_inc increments the selected field. Optional edit timeout
//          is enabled by defining CLOCK_TIME_SET_TIMEOUT_EN.
// Ports:
//   clk, rst                  : clock, synchronous active-low reset
//   btn_set, btn_inc          : single-cycle button pulses
//   time_ms_hr..time_ls_min   : current BCD time from the clock
//   load                      : one-cycle commit strobe
//   load_ms_hr..load_ls_min   : edited BCD time (shadow registers)
//   editing                   : high while editing hours or minutes
//   field_sel                 : 0 = hours, 1 = minutes (0 outside edit)
module clock_time_set
  import clock_time_set_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic [3:0] time_ms_hr,
  input  logic [3:0] time_ls_hr,
  input  logic [3:0] time_ms_min,
  input  logic [3:0] time_ls_min,
  output logic       load,
  output logic [3:0] load_ms_hr,
  output logic [3:0] load_ls_hr,
  output logic [3:0] load_ms_min,
  output logic [3:0] load_ls_min,
  output logic       editing,
  output logic       field_sel
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t     state_q, state_d;
  logic [3:0] ms_hr_q, ms_hr_d, ls_hr_q, ls_hr_d;
  logic [3:0] ms_min_q, ms_min_d, ls_min_q, ls_min_d;
  logic       load_q, load_d;
  logic       editing_q, editing_d;
  logic       field_sel_q, field_sel_d;

  logic [3:0] hr_inc_ms, hr_inc_ls, min_inc_ms, min_inc_ls;
  logic       timeout_hit;

  bcd_inc_wrap #(.MAX_MS(HR_MAX_MS), .MAX_LS(HR_MAX_LS)) u_hr_inc (
    .ms_i (ms_hr_q),
    .ls_i (ls_hr_q),
    .ms_o (hr_inc_ms),
    .ls_o (hr_inc_ls)
  );

  bcd_inc_wrap #(.MAX_MS(MIN_MAX_MS), .MAX_LS(MIN_MAX_LS)) u_min_inc (
    .ms_i (ms_min_q),
    .ls_i (ls_min_q),
    .ms_o (min_inc_ms),
    .ls_o (min_inc_ls)
  );

`ifdef CLOCK_TIME_SET_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_edit;

  // The counter sits at zero outside the edit states, so entry into SET_HR
  // starts from zero; the SET_HR -> SET_MIN step is itself a button pulse.
  always_comb begin
    in_edit     = (state_q == SET_HR) || (state_q == SET_MIN);
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
    if (!in_edit || btn_set || btn_inc) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
      timeout_hit = 1'b1;
      cnt_d       = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ms_hr_d  = ms_hr_q;
    ls_hr_d  = ls_hr_q;
    ms_min_d = ms_min_q;
    ls_min_d = ls_min_q;
    // The strobe trails the COMMIT state by one register stage, so the clock
    // samples it two edges after the final btn_set.
    load_d   = (state_q == COMMIT);

    unique case (state_q)
      IDLE: begin
        if (btn_set) begin
          state_d = SET_HR;
          if (bcd_in_range(time_ms_hr, time_ls_hr, HR_MAX_MS, HR_MAX_LS)) begin
            ms_hr_d = time_ms_hr;
            ls_hr_d = time_ls_hr;
          end else begin
            ms_hr_d = 4'd0;
            ls_hr_d = 4'd0;
          end
          if (bcd_in_range(time_ms_min, time_ls_min, MIN_MAX_MS, MIN_MAX_LS)) begin
            ms_min_d = time_ms_min;
            ls_min_d = time_ls_min;
          end else begin
            ms_min_d = 4'd0;
            ls_min_d = 4'd0;
          end
        end
      end
      SET_HR: begin
        if (btn_set) begin
          state_d = SET_MIN;
        end else if (btn_inc) begin
          ms_hr_d = hr_inc_ms;
          ls_hr_d = hr_inc_ls;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      SET_MIN: begin
        if (btn_set) begin
          state_d = COMMIT;
        end else if (btn_inc) begin
          ms_min_d = min_inc_ms;
          ls_min_d = min_inc_ls;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    editing_d   = (state_d == SET_HR) || (state_d == SET_MIN);
    field_sel_d = (state_d == SET_MIN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ms_hr_q     <= 4'd0;
      ls_hr_q     <= 4'd0;
      ms_min_q    <= 4'd0;
      ls_min_q    <= 4'd0;
      load_q      <= 1'b0;
      editing_q   <= 1'b0;
      field_sel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ms_hr_q     <= ms_hr_d;
      ls_hr_q     <= ls_hr_d;
      ms_min_q    <= ms_min_d;
      ls_min_q    <= ls_min_d;
      load_q      <= load_d;
      editing_q   <= editing_d;
      field_sel_q <= field_sel_d;
    end
  end

  assign load        = load_q;
  assign load_ms_hr  = ms_hr_q;
  assign load_ls_hr  = ls_hr_q;
  assign load_ms_min = ms_min_q;
  assign load_ls_min = ls_min_q;
  assign editing     = editing_q;
  assign field_sel   = field_sel_q;

endmodule

// File: tb/tb_clock_time_set.sv
// tb/tb_clock_time_set.sv - scoreboard bench for clock_time_set with a time-arithmetic reference model
module tb_clock_time_set;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_set = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] time_ms_hr = 4'd0, time_ls_hr = 4'd0, time_ms_min = 4'd0, time_ls_min = 4'd0;
  logic       load;
  logic [3:0] load_ms_hr, load_ls_hr, load_ms_min, load_ls_min;
  logic       editing, field_sel;

  always #5 clk = ~clk;

  clock_time_set #(.TIMEOUT_CYCLES(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_set     (btn_set),
    .btn_inc     (btn_inc),
    .time_ms_hr  (time_ms_hr),
    .time_ls_hr  (time_ls_hr),
    .time_ms_min (time_ms_min),
    .time_ls_min (time_ls_min),
    .load        (load),
    .load_ms_hr  (load_ms_hr),
    .load_ls_hr  (load_ls_hr),
    .load_ms_min (load_ms_min),
    .load_ls_min (load_ls_min),
    .editing     (editing),
    .field_sel   (field_sel)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  // Reference model: mode 0 = idle, 1 = editing hours, 2 = editing minutes.
  int m_mode = 0;
  int m_h = 0;
  int m_m = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int pack_time(input int h, input int m);
    return ((h / 10) << 12) | ((h % 10) << 8) | ((m / 10) << 4) | (m % 10);
  endfunction

  function automatic int dut_time();
    return int'({load_ms_hr, load_ls_hr, load_ms_min, load_ls_min});
  endfunction

  task automatic set_time(input int a, input int b, input int c, input int d);
    time_ms_hr  = 4'(a);
    time_ls_hr  = 4'(b);
    time_ms_min = 4'(c);
    time_ls_min = 4'(d);
  endtask

  task automatic press(input bit s, input bit i);
    int h, m;
    @(negedge clk);
    btn_set = s;
    btn_inc = i;
    case (m_mode)
      0: if (s) begin
        h = int'(time_ms_hr) * 10 + int'(time_ls_hr);
        m = int'(time_ms_min) * 10 + int'(time_ls_min);
        m_h = (time_ms_hr > 9 || time_ls_hr > 9 || h > 23) ? 0 : h;
        m_m = (time_ms_min > 9 || time_ls_min > 9 || m > 59) ? 0 : m;
        m_mode = 1;
      end
      1: if (s) m_mode = 2;
         else if (i) m_h = (m_h + 1) % 24;
      default: if (s) begin
        m_mode = 0;
        exp_q.push_back(pack_time(m_h, m_m));
      end else if (i) m_m = (m_m + 1) % 60;
    endcase
    @(negedge clk);
    btn_set = 1'b0;
    btn_inc = 1'b0;
    check("editing", int'(editing), int'(m_mode != 0));
    check("field_sel", int'(field_sel), int'(m_mode == 2));
    check("shadow", dut_time(), pack_time(m_h, m_m));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_mode = 0;
    m_h = 0;
    m_m = 0;
    check("reset_editing", int'(editing), 0);
    check("reset_shadow", dut_time(), 0);
  endtask

  // Monitor: every load strobe is matched against the oldest expected commit.
  bit prev_load = 1'b0;
  always @(negedge clk) begin
    if (load === 1'b1) begin
      check("load_single_cycle", int'(prev_load), 0);
      if (exp_q.size() == 0) check("spurious_load", 1, 0);
      else check("load_time", dut_time(), exp_q.pop_front());
    end
    prev_load = (load === 1'b1);
  end

  initial begin
    int op;
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(10);
    check("idle_outputs", int'({load, load_ms_hr, load_ls_hr, load_ms_min, load_ls_min, editing, field_sel}), 0);

    // Capture and commit
    set_time(1, 7, 2, 5);
    press(1, 0); press(1, 0); press(1, 0);
    idle(3);
    check("editing_after_commit", int'(editing), 0);

    // Hour wrap 23 -> 00
    set_time(2, 2, 1, 0);
    press(1, 0); press(0, 1); press(0, 1); press(1, 0); press(1, 0);
    idle(2);

    // 09 -> 10 and 19 -> 20 carries
    set_time(0, 8, 3, 0);
    press(1, 0); press(0, 1); press(0, 1); press(1, 0); press(1, 0);
    set_time(1, 8, 3, 0);
    press(1, 0); press(0, 1); press(0, 1); press(1, 0); press(1, 0);
    idle(2);

    // Minute wrap without hour carry
    set_time(0, 8, 5, 8);
    press(1, 0); press(1, 0); press(0, 1); press(0, 1); press(1, 0);
    idle(2);

    // Sanitised capture of an invalid time
    set_time(2, 5, 6, 1);
    press(1, 0); press(1, 0); press(1, 0);
    idle(2);

    // set+inc together: set wins
    set_time(1, 2, 3, 4);
    press(1, 0); press(1, 1); press(1, 0);
    idle(2);

    // Reset mid-edit discards the edit
    set_time(0, 5, 0, 5);
    press(1, 0); press(1, 0); press(0, 1);
    do_reset();
    idle(20);

    // Edit held indefinitely, or aborted by the timeout when enabled
    set_time(1, 1, 1, 1);
    press(1, 0);
`ifdef CLOCK_TIME_SET_TIMEOUT_EN
    idle(7);
    m_mode = 0;
    check("timeout_editing", int'(editing), 0);
    check("timeout_shadow_kept", dut_time(), pack_time(11, 11));
`else
    idle(100);
    check("no_timeout_editing", int'(editing), 1);
    press(1, 0); press(1, 0);
`endif
    idle(3);

    // Randomised operation mix
    for (int k = 0; k < 300; k++) begin
      set_time($urandom_range(0, 3), $urandom_range(0, 10), $urandom_range(0, 6), $urandom_range(0, 10));
      op = $urandom_range(0, 9);
      if (op <= 3) press(1, 0);
      else if (op <= 7) press(0, 1);
      else if (op == 8) press(1, 1);
      else if (m_mode != 0) do_reset();
      idle($urandom_range(0, 2));
    end
    if (m_mode == 1) press(1, 0);
    if (m_mode == 2) press(1, 0);
    idle(5);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
